// File: rtl/ttt_turn_ctrl_if.sv
// ttt_turn_ctrl_if
//   Bundle between the keypad/display side and the tic-tac-toe sequencer.
//   master : keypad side, drives start/key_valid/key_code and observes the game.
//   slave  : the sequencer, consumes key events and drives board/turn/result.
//   Signals:
//     start, key_valid, key_code[3:0]        keypad -> sequencer
//     board[17:0], turn_o, result[1:0],
//     move_count[3:0], state[2:0], ready,
//     move_ack, illegal, timeout             sequencer -> renderer / message mux
interface ttt_turn_ctrl_if;
  logic        start;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [17:0] board;
  logic        turn_o;
  logic [1:0]  result;
  logic [3:0]  move_count;
  logic [2:0]  state;
  logic        ready;
  logic        move_ack;
  logic        illegal;
  logic        timeout;

  modport master (
    output start, key_valid, key_code,
    input  board, turn_o, result, move_count, state, ready, move_ack, illegal, timeout
  );

  modport slave (
    input  start, key_valid, key_code,
    output board, turn_o, result, move_count, state, ready, move_ack, illegal, timeout
  );
endinterface

// File: rtl/ttt_turn_ctrl.sv
// ttt_turn_ctrl
//   Game sequencer for the tic-tac-toe board: validates key events against the
//   board, places stones, alternates turns, detects win/draw and optionally
//   expires a turn after TURN_TIMEOUT cycles.
//   Ports:
//     clk        system clock
//     rst        asynchronous, active-high reset
//     bus        ttt_turn_ctrl_if.slave (key events in, board/turn/result out)
//   Board encoding: cell k (1..9) occupies bits [19-2k:18-2k]; upper bit = O,
//   lower bit = X.
//   Build option: define TTT_UNDO_EN to add a 9-deep move history; key '*'
//   (code 10) then removes the last stone. Without it, code 10 is illegal.
module ttt_turn_ctrl #(
  parameter logic        FIRST_O      = 1'b0,
  parameter int unsigned TURN_TIMEOUT = 0,
  parameter int unsigned TO_W         = 32
) (
  input logic            clk,
  input logic            rst,
  ttt_turn_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_CHECK = 3'd2,
    S_EVAL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam bit              TO_EN   = (TURN_TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(TURN_TIMEOUT - 1) : '0;

  // One-hot cell select for codes 1..9; zero for every non-cell code.
  function automatic logic [8:0] cell_onehot(input logic [3:0] code);
    logic [8:0] oh;
    oh = 9'd0;
    if ((code >= 4'd1) && (code <= 4'd9)) begin
      oh = 9'd1 << (code - 4'd1);
    end else begin
      oh = 9'd0;
    end
    return oh;
  endfunction

  // Stones of one player as a 9-bit plane, bit i = cell i+1.
  function automatic logic [8:0] plane(input logic [17:0] b, input logic who);
    logic [8:0] p;
    p = 9'd0;
    for (int i = 0; i < 9; i++) begin
      p[i] = who ? b[17-2*i] : b[16-2*i];
    end
    return p;
  endfunction

  // Any of the 3 rows, 3 columns or 2 diagonals fully owned.
  function automatic logic has_line(input logic [8:0] p);
    return (&p[2:0]) | (&p[5:3]) | (&p[8:6]) |
           (p[0] & p[3] & p[6]) | (p[1] & p[4] & p[7]) | (p[2] & p[5] & p[8]) |
           (p[0] & p[4] & p[8]) | (p[2] & p[4] & p[6]);
  endfunction

  function automatic logic [17:0] place(input logic [17:0] b, input logic [8:0] oh,
                                        input logic who);
    logic [17:0] r;
    r = b;
    for (int i = 0; i < 9; i++) begin
      if (oh[i]) begin
        if (who) r[17-2*i] = 1'b1;
        else     r[16-2*i] = 1'b1;
      end
    end
    return r;
  endfunction

`ifdef TTT_UNDO_EN
  function automatic logic [17:0] clear_cell(input logic [17:0] b, input logic [8:0] oh);
    logic [17:0] r;
    r = b;
    for (int i = 0; i < 9; i++) begin
      if (oh[i]) begin
        r[17-2*i] = 1'b0;
        r[16-2*i] = 1'b0;
      end
    end
    return r;
  endfunction
`endif

  state_t          state_q;
  logic [17:0]     board_q;
  logic            turn_q;
  logic [1:0]      result_q;
  logic [3:0]      move_cnt_q;
  logic [3:0]      key_q;
  logic            ready_q;
  logic            move_ack_q;
  logic            illegal_q;
  logic            timeout_q;
  logic [TO_W-1:0] to_cnt_q;

  logic [8:0] key_oh_d;
  logic       legal_d;
  logic       win_d;

`ifdef TTT_UNDO_EN
  logic [3:0] hist_q [0:8];
  logic [8:0] undo_oh_d;
`endif

  // Decode the latched key against the board and test the mover for a line.
  always_comb begin
    key_oh_d = cell_onehot(key_q);
    legal_d  = (key_oh_d != 9'd0) &&
               ((key_oh_d & (plane(board_q, 1'b1) | plane(board_q, 1'b0))) == 9'd0);
    win_d    = has_line(plane(board_q, turn_q));
`ifdef TTT_UNDO_EN
    if (move_cnt_q != 4'd0) begin
      undo_oh_d = cell_onehot(hist_q[move_cnt_q - 4'd1]);
    end else begin
      undo_oh_d = 9'd0;
    end
`endif
  end

  // Game FSM with all outputs registered; start overrides every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      board_q    <= 18'd0;
      turn_q     <= FIRST_O;
      result_q   <= 2'b00;
      move_cnt_q <= 4'd0;
      key_q      <= 4'd0;
      ready_q    <= 1'b0;
      move_ack_q <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      to_cnt_q   <= '0;
`ifdef TTT_UNDO_EN
      for (int i = 0; i < 9; i++) hist_q[i] <= 4'd0;
`endif
    end else begin
      move_ack_q <= 1'b0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      if (bus.start) begin
        // Any pending key in this cycle is dropped.
        state_q    <= S_WAIT;
        board_q    <= 18'd0;
        turn_q     <= FIRST_O;
        result_q   <= 2'b00;
        move_cnt_q <= 4'd0;
        ready_q    <= 1'b1;
        to_cnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            ready_q <= 1'b0;
          end
          S_WAIT: begin
            if (bus.key_valid) begin
              key_q    <= bus.key_code;
              state_q  <= S_CHECK;
              ready_q  <= 1'b0;
              to_cnt_q <= '0;
            end else if (TO_EN && (to_cnt_q == TO_LAST)) begin
              // Turn expired: hand the move to the other player, stay in WAIT.
              timeout_q <= 1'b1;
              turn_q    <= ~turn_q;
              to_cnt_q  <= '0;
            end else if (TO_EN) begin
              to_cnt_q <= to_cnt_q + TO_W'(1);
            end else begin
              to_cnt_q <= '0;
            end
          end
          S_CHECK: begin
            if (legal_d) begin
              board_q    <= place(board_q, key_oh_d, turn_q);
              move_cnt_q <= move_cnt_q + 4'd1;
              move_ack_q <= 1'b1;
              state_q    <= S_EVAL;
`ifdef TTT_UNDO_EN
              hist_q[move_cnt_q] <= key_q;
`endif
            end
`ifdef TTT_UNDO_EN
            else if ((key_q == 4'd10) && (move_cnt_q != 4'd0)) begin
              // Undo skips EVAL: removing a stone can never create a result.
              board_q    <= clear_cell(board_q, undo_oh_d);
              move_cnt_q <= move_cnt_q - 4'd1;
              turn_q     <= ~turn_q;
              move_ack_q <= 1'b1;
              state_q    <= S_WAIT;
              ready_q    <= 1'b1;
              to_cnt_q   <= '0;
            end
`endif
            else begin
              illegal_q <= 1'b1;
              state_q   <= S_WAIT;
              ready_q   <= 1'b1;
              to_cnt_q  <= '0;
            end
          end
          S_EVAL: begin
            if (win_d) begin
              result_q <= turn_q ? 2'b10 : 2'b01;
              state_q  <= S_DONE;
            end else if (move_cnt_q == 4'd9) begin
              result_q <= 2'b11;
              state_q  <= S_DONE;
            end else begin
              turn_q   <= ~turn_q;
              state_q  <= S_WAIT;
              ready_q  <= 1'b1;
              to_cnt_q <= '0;
            end
          end
          S_DONE: begin
            ready_q <= 1'b0;
          end
          default: begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.board      = board_q;
  assign bus.turn_o     = turn_q;
  assign bus.result     = result_q;
  assign bus.move_count = move_cnt_q;
  assign bus.state      = state_q;
  assign bus.ready      = ready_q;
  assign bus.move_ack   = move_ack_q;
  assign bus.illegal    = illegal_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_ttt_turn_ctrl.sv
// tb_ttt_turn_ctrl
//   Directed bench for ttt_turn_ctrl. u_dut0 uses the default configuration
//   (no timeout); u_dut1 uses TURN_TIMEOUT=16. Inputs are driven on the falling
//   edge and outputs are sampled on the falling edge.
//   Honours TTT_UNDO_EN for the undo scenario.
module tb_ttt_turn_ctrl;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;
  int   to0_seen;

  ttt_turn_ctrl_if bus0 ();
  ttt_turn_ctrl_if bus1 ();

  ttt_turn_ctrl #(.FIRST_O(1'b0), .TURN_TIMEOUT(0), .TO_W(32)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  ttt_turn_ctrl #(.FIRST_O(1'b0), .TURN_TIMEOUT(16), .TO_W(8)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  always #5 clk = ~clk;

  // The untimed instance must never report an expired turn.
  always @(negedge clk) begin
    if (bus0.timeout === 1'b1) to0_seen++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit which, input logic st, input logic kv, input logic [3:0] code);
    if (which) begin
      bus1.start = st; bus1.key_valid = kv; bus1.key_code = code;
    end else begin
      bus0.start = st; bus0.key_valid = kv; bus0.key_code = code;
    end
  endtask

  task automatic do_start(input bit which);
    @(negedge clk);
    drive(which, 1'b1, 1'b0, 4'd0);
    @(negedge clk);
    drive(which, 1'b0, 1'b0, 4'd0);
  endtask

  // One key event; pulses checked one cycle after the key is taken, returns
  // after the full CHECK/EVAL turnaround.
  task automatic key_ev(input bit which, input logic [3:0] code, input logic exp_ack,
                        input logic exp_ill, input string tag);
    @(negedge clk);
    drive(which, 1'b0, 1'b1, code);
    @(negedge clk);
    drive(which, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    check_eq({tag, "_ack"}, which ? bus1.move_ack : bus0.move_ack, exp_ack);
    check_eq({tag, "_ill"}, which ? bus1.illegal  : bus0.illegal,  exp_ill);
    if (exp_ill) check_eq({tag, "_rdy"}, bus0.ready, 1'b1);
    @(negedge clk);
  endtask

  logic [3:0] draw_seq [0:8];

  initial begin
    clk = 1'b0; rst = 1'b1;
    n_checks = 0; n_errors = 0; to0_seen = 0;
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    draw_seq[0] = 4'd1; draw_seq[1] = 4'd2; draw_seq[2] = 4'd3;
    draw_seq[3] = 4'd5; draw_seq[4] = 4'd4; draw_seq[5] = 4'd6;
    draw_seq[6] = 4'd8; draw_seq[7] = 4'd7; draw_seq[8] = 4'd9;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset values
    check_eq("rst_state", bus0.state, 3'd0);
    check_eq("rst_board", bus0.board, 18'd0);
    check_eq("rst_turn",  bus0.turn_o, 1'b0);
    check_eq("rst_result", bus0.result, 2'b00);
    check_eq("rst_mc",    bus0.move_count, 4'd0);
    check_eq("rst_ready", bus0.ready, 1'b0);
    check_eq("rst_pulses", {bus0.move_ack, bus0.illegal, bus0.timeout}, 3'b000);

    // Keys in IDLE are ignored
    key_ev(1'b0, 4'd1, 1'b0, 1'b0, "idle_key");
    check_eq("idle_state", bus0.state, 3'd0);

    // X wins on row 1: 1,4,2,5,3
    do_start(1'b0);
    check_eq("start_state", bus0.state, 3'd1);
    check_eq("start_ready", bus0.ready, 1'b1);
    key_ev(1'b0, 4'd1, 1'b1, 1'b0, "w1");
    key_ev(1'b0, 4'd4, 1'b1, 1'b0, "w4");
    key_ev(1'b0, 4'd2, 1'b1, 1'b0, "w2");
    key_ev(1'b0, 4'd5, 1'b1, 1'b0, "w5");
    key_ev(1'b0, 4'd3, 1'b1, 1'b0, "w3");
    check_eq("win_board",  bus0.board, 18'h15A00);
    check_eq("win_result", bus0.result, 2'b01);
    check_eq("win_state",  bus0.state, 3'd4);
    check_eq("win_turn",   bus0.turn_o, 1'b0);
    check_eq("win_mc",     bus0.move_count, 4'd5);
    check_eq("win_ready",  bus0.ready, 1'b0);

    // Occupied cell and non-cell codes are rejected
    do_start(1'b0);
    check_eq("clr_result", bus0.result, 2'b00);
    check_eq("clr_board",  bus0.board, 18'd0);
    key_ev(1'b0, 4'd1, 1'b1, 1'b0, "i1");
    key_ev(1'b0, 4'd5, 1'b1, 1'b0, "i5");
    key_ev(1'b0, 4'd5, 1'b0, 1'b1, "rep5");
    check_eq("rep_board", bus0.board, 18'h10200);
    check_eq("rep_mc",    bus0.move_count, 4'd2);
    check_eq("rep_turn",  bus0.turn_o, 1'b0);
    check_eq("rep_state", bus0.state, 3'd1);
    key_ev(1'b0, 4'd0,  1'b0, 1'b1, "key0");
    key_ev(1'b0, 4'd11, 1'b0, 1'b1, "hash");
`ifndef TTT_UNDO_EN
    key_ev(1'b0, 4'd10, 1'b0, 1'b1, "star_no_undo");
`endif

    // Full board, no line: draw
    do_start(1'b0);
    for (int i = 0; i < 9; i++) key_ev(1'b0, draw_seq[i], 1'b1, 1'b0, "draw");
    check_eq("draw_mc",     bus0.move_count, 4'd9);
    check_eq("draw_result", bus0.result, 2'b11);
    check_eq("draw_state",  bus0.state, 3'd4);
    check_eq("draw_board",  bus0.board, 18'h196A5);
    check_eq("draw_turn",   bus0.turn_o, 1'b0);
    key_ev(1'b0, 4'd1, 1'b0, 1'b0, "done_key");
    check_eq("done_board",  bus0.board, 18'h196A5);

    // Long idle in WAIT on the untimed instance
    do_start(1'b0);
    repeat (40) @(negedge clk);
    check_eq("notimeout_turn", bus0.turn_o, 1'b0);

    // start together with key_valid while in CHECK
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 4'd1);
    @(negedge clk);
    check_eq("chk_state", bus0.state, 3'd2);
    drive(1'b0, 1'b1, 1'b1, 4'd2);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("abort_state", bus0.state, 3'd1);
    check_eq("abort_board", bus0.board, 18'd0);
    check_eq("abort_mc",    bus0.move_count, 4'd0);
    check_eq("abort_ack",   bus0.move_ack, 1'b0);
    check_eq("abort_ready", bus0.ready, 1'b1);

    // start together with key_valid in WAIT: key dropped
    drive(1'b0, 1'b1, 1'b1, 4'd3);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    check_eq("sk_state", bus0.state, 3'd1);

    // rst while in EVAL
    drive(1'b0, 1'b0, 1'b1, 4'd7);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    @(negedge clk);
    check_eq("eval_state", bus0.state, 3'd3);
    check_eq("eval_board", bus0.board, 18'h00010);
    rst = 1'b1;
    #1;
    check_eq("arst_state", bus0.state, 3'd0);
    check_eq("arst_board", bus0.board, 18'd0);
    check_eq("arst_mc",    bus0.move_count, 4'd0);
    check_eq("arst_ready", bus0.ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Timeout after 16 idle cycles, then a key on the expiry cycle wins
    do_start(1'b1);
    repeat (15) @(negedge clk);
    check_eq("to_early", bus1.timeout, 1'b0);
    @(negedge clk);
    check_eq("to_pulse", bus1.timeout, 1'b1);
    check_eq("to_turn",  bus1.turn_o, 1'b1);
    check_eq("to_state", bus1.state, 3'd1);
    @(negedge clk);
    check_eq("to_one_cycle", bus1.timeout, 1'b0);
    repeat (14) @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 4'd5);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    check_eq("tokey_nopulse", bus1.timeout, 1'b0);
    check_eq("tokey_state",   bus1.state, 3'd2);
    check_eq("tokey_turn",    bus1.turn_o, 1'b1);
    @(negedge clk);
    check_eq("tokey_ack",   bus1.move_ack, 1'b1);
    check_eq("tokey_board", bus1.board, 18'h00200);

`ifdef TTT_UNDO_EN
    do_start(1'b0);
    key_ev(1'b0, 4'd1, 1'b1, 1'b0, "u1");
    key_ev(1'b0, 4'd5, 1'b1, 1'b0, "u5");
    key_ev(1'b0, 4'd10, 1'b1, 1'b0, "undo1");
    check_eq("undo1_board", bus0.board, 18'h10000);
    check_eq("undo1_mc",    bus0.move_count, 4'd1);
    check_eq("undo1_turn",  bus0.turn_o, 1'b1);
    check_eq("undo1_state", bus0.state, 3'd1);
    key_ev(1'b0, 4'd10, 1'b1, 1'b0, "undo2");
    check_eq("undo2_board", bus0.board, 18'd0);
    check_eq("undo2_mc",    bus0.move_count, 4'd0);
    check_eq("undo2_turn",  bus0.turn_o, 1'b0);
    key_ev(1'b0, 4'd10, 1'b0, 1'b1, "undo3");
`endif

    check_eq("untimed_timeouts", to0_seen, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
